// File: rtl/alu_seq_if.sv
// Handshake and operand/result bundle between the CPU control path and alu_seq.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       alu_ctrl;
  logic [WIDTH-1:0] in_A;
  logic [WIDTH-1:0] in_B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_hi;
  logic             zero;
  logic             ovf;
  logic             dz;

  modport master (
    output start, alu_ctrl, in_A, in_B,
    input  busy, done, res, res_hi, zero, ovf, dz
  );

  modport slave (
    input  start, alu_ctrl, in_A, in_B,
    output busy, done, res, res_hi, zero, ovf, dz
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with single-cycle logic/arith/shift ops and iterative
// radix-2 unsigned multiply and restoring divide behind a start/busy/done
// handshake. Results and flags hold until the next done pulse.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_NOR  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLL  = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  // hi/lo form the shared shift register: {acc, multiplier} for MUL,
  // {remainder, dividend->quotient} for DIV. opd is the latched
  // multiplicand or divisor.
  logic [WIDTH-1:0] hi, hi_n, lo, lo_n, opd, opd_n;
  logic [WIDTH-1:0] res_q, res_n, res_hi_q, res_hi_n;
  logic             zero_q, zero_n, ovf_q, ovf_n, dz_q, dz_n, done_q, done_n;

  logic [WIDTH-1:0] a, b, sum, diff;
  logic [SHW-1:0]   sh;

  assign a    = bus.in_A;
  assign b    = bus.in_B;
  assign sh   = a[SHW-1:0];
  assign sum  = a + b;
  assign diff = a - b;

  logic [WIDTH-1:0] sc_res, sc_hi;
  logic             sc_ovf, sc_dz, sc_legal;

  // Single-cycle result straight from the live operands (used only on accept).
  always_comb begin
    sc_res   = '0;
    sc_hi    = '0;
    sc_ovf   = 1'b0;
    sc_dz    = 1'b0;
    sc_legal = 1'b1;
    case (bus.alu_ctrl)
      OP_ADD: begin
        sc_res = sum;
        sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff;
        sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_res = a & b;
      OP_NOR:  sc_res = ~(a | b);
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  sc_res = b << sh;
      OP_SRL:  sc_res = b >> sh;
      OP_SRA:  sc_res = $signed(b) >>> sh;
      OP_DIVU: begin
        // only reached here for B == 0; nonzero divisors iterate
        sc_res = '1;
        sc_hi  = a;
        sc_dz  = 1'b1;
      end
      default: sc_legal = 1'b0;
    endcase
  end

  // One multiply step: conditionally add multiplicand, shift {carry,acc,mplr} right.
  logic [WIDTH-1:0] mul_add;
  logic [WIDTH:0]   mul_sum;
  assign mul_add = lo[0] ? opd : '0;
  assign mul_sum = {1'b0, hi} + {1'b0, mul_add};

  // One restoring-divide step: shift in next dividend bit, subtract if it fits.
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_sub, div_rem;
  logic             div_ge;
  assign div_sh  = {hi, lo[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, opd};
  assign div_sub = div_sh[WIDTH-1:0] - opd;
  assign div_rem = div_ge ? div_sub : div_sh[WIDTH-1:0];

  // Next-state, iteration datapath and result capture.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hi_n     = hi;
    lo_n     = lo;
    opd_n    = opd;
    res_n    = res_q;
    res_hi_n = res_hi_q;
    zero_n   = zero_q;
    ovf_n    = ovf_q;
    dz_n     = dz_q;
    done_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.alu_ctrl == OP_MULU) begin
            state_n = S_MUL;
            cnt_n   = CW'(WIDTH);
            hi_n    = '0;
            lo_n    = b;
            opd_n   = a;
          end else if (bus.alu_ctrl == OP_DIVU && b != '0) begin
            state_n = S_DIV;
            cnt_n   = CW'(WIDTH);
            hi_n    = '0;
            lo_n    = a;
            opd_n   = b;
          end else begin
            res_n    = sc_res;
            res_hi_n = sc_hi;
            zero_n   = sc_legal && (sc_res == '0);
            ovf_n    = sc_ovf;
            dz_n     = sc_dz;
            done_n   = 1'b1;
          end
        end
      end
      S_MUL: begin
        hi_n  = mul_sum[WIDTH:1];
        lo_n  = {mul_sum[0], lo[WIDTH-1:1]};
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state_n  = S_IDLE;
          res_n    = {mul_sum[0], lo[WIDTH-1:1]};
          res_hi_n = mul_sum[WIDTH:1];
          zero_n   = ({mul_sum[0], lo[WIDTH-1:1]} == '0);
          ovf_n    = 1'b0;
          dz_n     = 1'b0;
          done_n   = 1'b1;
        end
      end
      S_DIV: begin
        hi_n  = div_rem;
        lo_n  = {lo[WIDTH-2:0], div_ge};
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state_n  = S_IDLE;
          res_n    = {lo[WIDTH-2:0], div_ge};
          res_hi_n = div_rem;
          zero_n   = ({lo[WIDTH-2:0], div_ge} == '0);
          ovf_n    = 1'b0;
          dz_n     = 1'b0;
          done_n   = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      opd      <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      hi       <= hi_n;
      lo       <= lo_n;
      opd      <= opd_n;
      res_q    <= res_n;
      res_hi_q <= res_hi_n;
      zero_q   <= zero_n;
      ovf_q    <= ovf_n;
      dz_q     <= dz_n;
      done_q   <= done_n;
    end
  end

  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = done_q;
  assign bus.res    = res_q;
  assign bus.res_hi = res_hi_q;
  assign bus.zero   = zero_q;
  assign bus.ovf    = ovf_q;
  assign bus.dz     = dz_q;
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the datapath ALU for the multi-cycle CPU core.
- Adds a wider opcode set: add, sub, logic, set-less-than, shifts, iterative unsigned multiply and iterative unsigned divide.
- Uses a start/busy/done handshake so the control FSM can stall on multi-cycle operations.
- Operand source muxing (PC/register/immediate) stays outside; this block sees final operands.

Parameters:
- WIDTH, 32, operand/result width in bits; >=4, power of two.
- SHW, log2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- alu_ctrl  in  4  opcode, sampled with start
- in_A  in  WIDTH  operand A; sampled with start
- in_B  in  WIDTH  operand B; sampled with start
- busy  out  1  high while an operation is in flight, including the accepting cycle's successors up to done
- done  out  1  one-cycle pulse: res/res_hi/flags valid
- res  out  WIDTH  primary result (low product / quotient)
- res_hi  out  WIDTH  high product / remainder; 0 for other ops
- zero  out  1  res == 0
- ovf  out  1  signed overflow, ADD/SUB only
- dz  out  1  divide by zero, DIVU only

Behaviour:
- Reset (async, rst=1): state=IDLE; busy, done, zero, ovf and dz = 0; res and res_hi = 0; iteration counter = 0.
- A reset mid-operation abandons the operation; no done is produced.
- Opcodes:
  - 0000 ADD: A+B
  - 0001 SUB: A-B
  - 0010 AND
  - 0011 NOR
  - 0100 OR
  - 0101 XOR
  - 0110 SLT: signed, res=1/0
  - 0111 SLTU
  - 1000 SLL: B<<A[SHW-1:0]
  - 1001 SRL
  - 1010 SRA: arithmetic
  - 1100 MULU: {res_hi,res}=A*B, unsigned, 2*WIDTH bits
  - 1101 DIVU: res=A/B, res_hi=A%B
  - 1011, 1110, 1111: illegal; res=0, res_hi=0, flags 0, completes as single-cycle.
- FSM states: IDLE, MUL, DIV.
  - IDLE + start, single-cycle op: at the accepting edge, register res/flags and pulse done=1 for exactly one cycle; stay IDLE; busy stays 0. Latency 1 edge.
  - IDLE + start, MULU: latch operands, clear accumulator, counter=WIDTH, go MUL, busy=1.
    - MUL: one shift-add step per edge (radix-2), counter decrements.
    - On the edge where counter reaches 0: load {res_hi,res}, done=1, busy=0, return to IDLE.
    - done is high WIDTH edges after the accepting edge.
  - IDLE + start, DIVU with B!=0: restoring shift-subtract, one quotient bit per edge, same timing as MUL.
  - DIVU with B==0: no iteration. At the accepting edge: res=all ones, res_hi=A, dz=1, done=1. Latency 1.
- start while busy=1: ignored; alu_ctrl and operands are not resampled.
- start is honoured on the same edge as done only if state is IDLE. Back-to-back single-cycle ops therefore give done on consecutive cycles.
- Operands in_A/in_B may change after acceptance without affecting the in-flight operation.
- Result holding:
  - res, res_hi, zero, ovf and dz update only on a done edge and hold until the next done.
  - zero is computed from the new res.
  - ovf=1 when operand signs imply a sign flip: ADD with same-sign inputs, SUB with differing-sign inputs, and the result sign differs. ovf is 0 for all other ops.
- Shifts: amount = A[SHW-1:0]; upper bits of A are ignored. An amount of 0 returns B unchanged.
- Wrap-around: ADD/SUB are modulo 2^WIDTH; no saturation.

Test Plan:
- Reset mid-MULU: start MULU A=3 B=5, assert rst at cycle 4 -> all outputs 0, no done pulse; a new ADD 1+1 after release -> res=2, done 1 cycle later.
- WIDTH=32 single-cycle ops:
  - ADD 0x7FFFFFFF+1 -> res=0x80000000, ovf=1, zero=0.
  - SUB 5-5 -> res=0, zero=1.
  - SLT 0xFFFFFFFF,1 -> res=1; SLTU same operands -> res=0.
  - SRA B=0x80000000 A=4 -> res=0xF8000000.
- MULU 0xFFFFFFFF*0xFFFFFFFF -> done exactly 32 edges after accept, res=0x00000001, res_hi=0xFFFFFFFE, busy high for 32 cycles, start pulses during busy ignored.
- DIVU 100/7 -> res=14, res_hi=2, 32-edge latency.
- DIVU 9/0 -> res=0xFFFFFFFF, res_hi=9, dz=1, done after 1 edge.
- Back-to-back: AND, NOR, XOR issued on consecutive cycles -> three consecutive done pulses with correct results.
- Illegal opcode 1111 -> res=0, done after 1 edge.
- Repeat one MULU and one DIVU at WIDTH=8: 200*3 -> res=0x58, res_hi=0x02, latency 8.
